// File: rtl/hazard_stall_if.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_stall_if
//  Brief    : Pipeline-side signal bundle for hazard_stall_unit. When
//             STALL_STATS_EN is defined it also carries the stall counters.
//  Revision : 1.0 - initial release
// ============================================================================
interface hazard_stall_if #(
    parameter int CNT_W = 16
);
    logic [4:0] if_id_rs;
    logic [4:0] if_id_rt;
    logic       id_uses_rt;
    logic       id_reads_hilo;
    logic       id_is_mdu;
    logic       id_ex_mem_read;
    logic [4:0] id_ex_rt;
    logic       ex_mdu_start;
    logic       ex_branch_taken;
    logic       pc_write;
    logic       if_id_write;
    logic       id_ex_bubble;
    logic       if_id_flush;
    logic       mdu_busy;
`ifdef STALL_STATS_EN
    logic [CNT_W-1:0] load_stall_cnt;
    logic [CNT_W-1:0] mdu_stall_cnt;
`endif

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("hazard_stall_if: CNT_W must be at least 1");
    end

    modport master (
        output if_id_rs, if_id_rt, id_uses_rt, id_reads_hilo, id_is_mdu,
        output id_ex_mem_read, id_ex_rt, ex_mdu_start, ex_branch_taken,
        input  pc_write, if_id_write, id_ex_bubble, if_id_flush, mdu_busy
`ifdef STALL_STATS_EN
        , input load_stall_cnt, mdu_stall_cnt
`endif
    );

    modport slave (
        input  if_id_rs, if_id_rt, id_uses_rt, id_reads_hilo, id_is_mdu,
        input  id_ex_mem_read, id_ex_rt, ex_mdu_start, ex_branch_taken,
        output pc_write, if_id_write, id_ex_bubble, if_id_flush, mdu_busy
`ifdef STALL_STATS_EN
        , output load_stall_cnt, mdu_stall_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_stall_unit
//  Brief    : Load-use / MDU-busy stall and taken-branch flush control.
//             Optional STALL_STATS_EN adds saturating per-cause stall counters.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_unit #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  wire logic     clk,
    input  wire logic     rst,
    hazard_stall_if.slave hz
);
    if (MDU_LAT < 2 || MDU_LAT > 15 || CNT_W < 1) begin : g_bad_param
        $error("hazard_stall_unit: MDU_LAT must be 2..15 and CNT_W >= 1");
    end

    localparam logic [3:0] C_MDU_START_CNT = 4'(MDU_LAT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_mdu_cnt;
    logic [3:0] w_mdu_cnt_nxt;
    logic       r_rst_hold;

    logic       w_load_use;
    logic       w_mdu_busy;
    logic       w_mdu_stall;
    logic       w_stall;

    // r_rst_hold keeps the outputs in their reset pattern from reset
    // assertion until the first clock edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mdu_cnt  <= 4'd0;
            r_rst_hold <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_mdu_cnt  <= w_mdu_cnt_nxt;
            r_rst_hold <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_mdu_cnt_nxt = r_mdu_cnt;
        case (r_state)
            ST_IDLE: begin
                if (hz.ex_mdu_start) begin
                    w_state_nxt   = ST_BUSY;
                    w_mdu_cnt_nxt = C_MDU_START_CNT;
                end
            end
            ST_BUSY: begin
                if (hz.ex_mdu_start) begin
                    w_mdu_cnt_nxt = C_MDU_START_CNT;
                end else if (r_mdu_cnt <= 4'd1) begin
                    w_state_nxt   = ST_IDLE;
                    w_mdu_cnt_nxt = 4'd0;
                end else begin
                    w_mdu_cnt_nxt = r_mdu_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_mdu_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign w_load_use  = hz.id_ex_mem_read && (hz.id_ex_rt != 5'd0) &&
                         ((hz.id_ex_rt == hz.if_id_rs) ||
                          (hz.id_uses_rt && (hz.id_ex_rt == hz.if_id_rt)));
    assign w_mdu_busy  = (r_state == ST_BUSY);
    assign w_mdu_stall = w_mdu_busy && (hz.id_reads_hilo || hz.id_is_mdu);
    assign w_stall     = (w_load_use || w_mdu_stall) && !hz.ex_branch_taken;

    always_comb begin
        hz.pc_write     = !w_stall;
        hz.if_id_write  = !w_stall;
        hz.id_ex_bubble = w_stall || hz.ex_branch_taken;
        hz.if_id_flush  = hz.ex_branch_taken;
        hz.mdu_busy     = w_mdu_busy;
        if (r_rst_hold) begin
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.id_ex_bubble = 1'b1;
            hz.if_id_flush  = 1'b1;
        end
    end

`ifdef STALL_STATS_EN
    logic [CNT_W-1:0] r_load_stall_cnt;
    logic [CNT_W-1:0] r_mdu_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_stall_cnt <= '0;
            r_mdu_stall_cnt  <= '0;
        end else if (!r_rst_hold && w_stall) begin
            if (w_load_use && !(&r_load_stall_cnt)) begin
                r_load_stall_cnt <= r_load_stall_cnt + 1'b1;
            end
            if (w_mdu_stall && !(&r_mdu_stall_cnt)) begin
                r_mdu_stall_cnt <= r_mdu_stall_cnt + 1'b1;
            end
        end
    end

    assign hz.load_stall_cnt = r_load_stall_cnt;
    assign hz.mdu_stall_cnt  = r_mdu_stall_cnt;
`endif

    a_no_start_while_busy : assert property (
        @(posedge clk) disable iff (rst) !(hz.ex_mdu_start && w_mdu_busy)
    ) else $error("hazard_stall_unit: ex_mdu_start while MDU busy");

    a_no_start_with_branch : assert property (
        @(posedge clk) disable iff (rst) !(hz.ex_mdu_start && hz.ex_branch_taken)
    ) else $error("hazard_stall_unit: ex_mdu_start with ex_branch_taken");

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_stall_unit
//  Brief    : Directed-vector scoreboard bench for hazard_stall_unit (MDU_LAT=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    hazard_stall_if #(.CNT_W(4)) bus ();

    hazard_stall_unit #(.MDU_LAT(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       hilo;
        logic       is_mdu;
        logic       mem_read;
        logic [4:0] ex_rt;
        logic       start;
        logic       br;
    } stim_t;

    // outs = {pc_write, if_id_write, id_ex_bubble, if_id_flush, mdu_busy}
    typedef struct packed {
        logic       chk;
        logic [4:0] outs;
        logic       chk_cnt;
        int         lcnt;
        int         mcnt;
        int         id;
    } exp_t;

    localparam logic [4:0] RUN     = 5'b11000;
    localparam logic [4:0] STALL   = 5'b00100;
    localparam logic [4:0] RUN_B   = 5'b11001;
    localparam logic [4:0] STALL_B = 5'b00101;
    localparam logic [4:0] BR      = 5'b11110;
    localparam logic [4:0] BR_B    = 5'b11111;
    localparam logic [4:0] RST     = 5'b00110;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   vec_id   = 0;

    function automatic stim_t mk(logic r, logic [4:0] rs, logic [4:0] rt, logic uses_rt,
                                 logic hilo, logic is_mdu, logic mem_read,
                                 logic [4:0] ex_rt, logic start, logic br);
        stim_t s;
        s = '{r, rs, rt, uses_rt, hilo, is_mdu, mem_read, ex_rt, start, br};
        return s;
    endfunction

    task automatic apply(input stim_t s, input logic chk, input logic [4:0] outs,
                         input logic chk_cnt, input int lcnt, input int mcnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst                 = s.rst;
        bus.if_id_rs        = s.rs;
        bus.if_id_rt        = s.rt;
        bus.id_uses_rt      = s.uses_rt;
        bus.id_reads_hilo   = s.hilo;
        bus.id_is_mdu       = s.is_mdu;
        bus.id_ex_mem_read  = s.mem_read;
        bus.id_ex_rt        = s.ex_rt;
        bus.ex_mdu_start    = s.start;
        bus.ex_branch_taken = s.br;
        e = '{chk, outs, chk_cnt, lcnt, mcnt, vec_id};
        q.push_back(e);
        vec_id++;
    endtask

    // Monitor: one expected entry per cycle, compared at the falling edge.
    initial begin : monitor
        exp_t       e;
        logic [4:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {bus.pc_write, bus.if_id_write, bus.id_ex_bubble,
                       bus.if_id_flush, bus.mdu_busy};
                if (e.chk) begin
                    n_assert++;
                    if (act !== e.outs) begin
                        n_fail++;
                        $display("FAIL outs vec%0d: got %b expected %b", e.id, act, e.outs);
                    end
                end
`ifdef STALL_STATS_EN
                if (e.chk_cnt) begin
                    n_assert++;
                    if (int'(bus.load_stall_cnt) != e.lcnt) begin
                        n_fail++;
                        $display("FAIL load_stall_cnt vec%0d: got %0d expected %0d",
                                 e.id, bus.load_stall_cnt, e.lcnt);
                    end
                    n_assert++;
                    if (int'(bus.mdu_stall_cnt) != e.mcnt) begin
                        n_fail++;
                        $display("FAIL mdu_stall_cnt vec%0d: got %0d expected %0d",
                                 e.id, bus.mdu_stall_cnt, e.mcnt);
                    end
                end
`endif
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bus.if_id_rs        = 5'd0;
        bus.if_id_rt        = 5'd0;
        bus.id_uses_rt      = 1'b0;
        bus.id_reads_hilo   = 1'b0;
        bus.id_is_mdu       = 1'b0;
        bus.id_ex_mem_read  = 1'b0;
        bus.id_ex_rt        = 5'd0;
        bus.ex_mdu_start    = 1'b0;
        bus.ex_branch_taken = 1'b0;

        // Reset state, then release (release cycle not compared)
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, RST, 1'b0, 0, 0);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, RUN, 1'b0, 0, 0);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, RUN, 1'b0, 0, 0);

        // Load-use on rs, then clears
        apply(mk(0, 5, 0, 0, 0, 0, 1, 5, 0, 0), 1'b1, STALL, 1'b0, 0, 0);
        apply(mk(0, 5, 0, 0, 0, 0, 0, 5, 0, 0), 1'b1, RUN,   1'b0, 0, 0);
        // Load-use on rt when rt is a source
        apply(mk(0, 3, 9, 1, 0, 0, 1, 9, 0, 0), 1'b1, STALL, 1'b0, 0, 0);
        // rt matches but not read; load into r0
        apply(mk(0, 1, 7, 0, 0, 0, 1, 7, 0, 0), 1'b1, RUN,   1'b0, 0, 0);
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b1, RUN,   1'b0, 0, 0);
        // Taken branch outranks load-use
        apply(mk(0, 5, 0, 0, 0, 0, 1, 5, 0, 1), 1'b1, BR,    1'b0, 0, 0);

        // MDU start with MFHI held: 3 busy stall cycles then proceed
        apply(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0), 1'b1, RUN,     1'b0, 0, 0);
        apply(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b1, STALL_B, 1'b0, 0, 0);
        apply(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b1, STALL_B, 1'b0, 0, 0);
        apply(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b1, STALL_B, 1'b0, 0, 0);
        apply(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b1, RUN,     1'b0, 0, 0);

        // Back-to-back MDU op, branch during busy, busy with no reader
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1, RUN,     1'b0, 0, 0);
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 1'b1, STALL_B, 1'b0, 0, 0);
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1), 1'b1, BR_B,    1'b0, 0, 0);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, RUN_B,   1'b0, 0, 0);
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 1'b1, RUN,     1'b0, 0, 0);

        // Reset in the second busy cycle
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1, RUN,   1'b0, 0, 0);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, RUN_B, 1'b0, 0, 0);
        apply(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b1, RST,   1'b0, 0, 0);
        apply(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b0, RUN,   1'b0, 0, 0);
        apply(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b1, RUN,   1'b1, 0, 0);

        // 20 consecutive load-use cycles: load counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            apply(mk(0, 6, 0, 0, 0, 0, 1, 6, 0, 0), 1'b1, STALL, 1'b1,
                  (i > 15) ? 15 : i, 0);
        end
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, RUN, 1'b1, 15, 0);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
